// File: rtl/rc4_pkg.sv
// Shared types, widths and key-indexing helper for the RC4 stream controller.
// No logic of its own; imported by the controller and the S-box register file.
// Key bytes are stored MSB-first: byte 0 sits in the top bits of the key vector.
package rc4_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        KSA,
        DROP,
        RUN
    } rc4_state_e;

    localparam int RC4_BYTE_W      = 8;
    localparam int RC4_MAX_KEY_LEN = 32;

    function automatic logic [RC4_BYTE_W-1:0] rc4_key_byte(
        input logic [8*RC4_MAX_KEY_LEN-1:0] key,
        input int                           key_len,
        input int                           idx
    );
        int pos;
        pos = key_len - 1 - (idx % key_len);
        return key[8*pos +: 8];
    endfunction

endpackage

// File: rtl/rc4_sbox_regs.sv
// RC4 S-box: D x SBOX_AW flops, two combinational reads, keystream read at S[a]+S[b].
// Latency: reads are combinational, fill/swap writes land on the next clock edge.
// Backpressure: none; the owner decides per cycle whether to fill or swap.
module rc4_sbox_regs
    import rc4_pkg::*;
#(
    parameter int SBOX_AW = 8
) (
    input  logic               clk,
    input  logic               fill_en,
    input  logic               swap_en,
    input  logic [SBOX_AW-1:0] addr_a,
    input  logic [SBOX_AW-1:0] addr_b,
    output logic [SBOX_AW-1:0] rd_a,
    output logic [SBOX_AW-1:0] ks
);

    localparam int D = 1 << SBOX_AW;

    logic [SBOX_AW-1:0] mem [D];
    logic [SBOX_AW-1:0] rd_b;
    logic [SBOX_AW-1:0] ksum;

    assign rd_a = mem[addr_a];
    assign rd_b = mem[addr_b];
    assign ksum = rd_a + rd_b;

    // Keystream must see the array after this cycle's swap, which is not yet written.
    always_comb begin
        ks = mem[ksum];
        if (ksum == addr_b) ks = rd_a;
        if (ksum == addr_a) ks = rd_b;
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            mem[addr_a] <= addr_a;
        end else if (swap_en) begin
            mem[addr_a] <= rd_b;
            mem[addr_b] <= rd_a;
        end
    end

endmodule

// File: rtl/rc4_stream_ctrl.sv
// RC4 rekey sequencer + byte XOR engine; RC4_DROP_EN adds a DROP_N-step keystream discard.
// Latency: ready 2*D (+DROP_N) cycles after start; ciphertext one cycle after pt accept.
// Backpressure: pt_ready = !ct_valid || ct_ready, forced low while start is asserted.
module rc4_stream_ctrl
    import rc4_pkg::*;
#(
    parameter int KEY_LEN = 5,
    parameter int SBOX_AW = 8,
    parameter int DROP_N  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*KEY_LEN-1:0]  key_in,
    output logic                  busy,
    output logic                  ready,
    input  logic                  pt_valid,
    input  logic [RC4_BYTE_W-1:0] pt_data,
    output logic                  pt_ready,
    output logic                  ct_valid,
    output logic [RC4_BYTE_W-1:0] ct_data,
    input  logic                  ct_ready
);

`ifdef RC4_DROP_EN
    localparam bit DROP_ON = 1'b1;
`else
    localparam bit DROP_ON = 1'b0;
`endif

    localparam logic [SBOX_AW-1:0] IDX_ONE = SBOX_AW'(1);

    rc4_state_e state, state_d;

    logic [SBOX_AW-1:0]           i_q, j_q, i_nx;
    logic [8*KEY_LEN-1:0]         key_q;
    logic [8*RC4_MAX_KEY_LEN-1:0] key_ext;
    logic [RC4_BYTE_W-1:0]        kb;
    logic [SBOX_AW-1:0]           addr_a, addr_b, rd_a, ks;
    logic                         fill_en, swap_en, start_ok, accept, prga;
`ifdef RC4_DROP_EN
    logic [15:0]                  drop_cnt;
`endif

    assign start_ok = start && (state == IDLE || state == RUN);
    assign pt_ready = (state == RUN) && !start && (!ct_valid || ct_ready);
    assign accept   = pt_valid && pt_ready;
    assign prga     = (state == RUN || state == DROP);

    always_comb begin
        key_ext                = '0;
        key_ext[8*KEY_LEN-1:0] = key_q;
    end

    assign kb   = rc4_key_byte(key_ext, KEY_LEN, int'(i_q));
    assign i_nx = i_q + IDX_ONE;

    // KSA walks S[i] at the current i; PRGA pre-increments i before touching S.
    always_comb begin
        addr_a  = prga ? i_nx : i_q;
        addr_b  = (state == KSA) ? (j_q + rd_a + kb[SBOX_AW-1:0]) : (j_q + rd_a);
        fill_en = (state == INIT);
        swap_en = (state == KSA) || (state == DROP) || accept;
    end

    rc4_sbox_regs #(.SBOX_AW(SBOX_AW)) u_sbox (
        .clk     (clk),
        .fill_en (fill_en),
        .swap_en (swap_en),
        .addr_a  (addr_a),
        .addr_b  (addr_b),
        .rd_a    (rd_a),
        .ks      (ks)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        busy    = 1'b0;
        ready   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_d = INIT;
            end
            INIT: begin
                busy = 1'b1;
                if (&i_q) state_d = KSA;
            end
            KSA: begin
                busy = 1'b1;
                if (&i_q) state_d = (DROP_ON && DROP_N != 0) ? DROP : RUN;
            end
`ifdef RC4_DROP_EN
            DROP: begin
                busy = 1'b1;
                if (drop_cnt == 16'(DROP_N - 1)) state_d = RUN;
            end
`endif
            RUN: begin
                ready = 1'b1;
                if (start) state_d = INIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q      <= '0;
            j_q      <= '0;
            key_q    <= '0;
            ct_valid <= 1'b0;
            ct_data  <= '0;
`ifdef RC4_DROP_EN
            drop_cnt <= '0;
`endif
        end else if (start_ok) begin
            key_q    <= key_in;
            i_q      <= '0;
            j_q      <= '0;
            ct_valid <= 1'b0;
`ifdef RC4_DROP_EN
            drop_cnt <= '0;
`endif
        end else begin
            case (state)
                INIT: i_q <= i_nx;
                KSA: begin
                    i_q <= i_nx;
                    j_q <= (&i_q) ? '0 : addr_b;
                end
`ifdef RC4_DROP_EN
                DROP: begin
                    i_q      <= i_nx;
                    j_q      <= addr_b;
                    drop_cnt <= drop_cnt + 16'd1;
                end
`endif
                RUN: begin
                    if (accept) begin
                        i_q      <= i_nx;
                        j_q      <= addr_b;
                        ct_data  <= pt_data ^ RC4_BYTE_W'(ks);
                        ct_valid <= 1'b1;
                    end else if (ct_ready) begin
                        ct_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_stream_ctrl.sv
// Scoreboarded bench for rc4_stream_ctrl: behavioural RC4 model feeds an expected-ct queue.
// KEY_LEN=12 lets "Key"/"Wiki"/"Secret" repeat exactly, giving the same schedule as their native lengths.
module tb_rc4_stream_ctrl;

    localparam int KL = 12;
    localparam int KW = 8 * KL;
`ifdef RC4_DROP_EN
    localparam int DROP_STEPS = 4;
`else
    localparam int DROP_STEPS = 0;
`endif
    localparam int LAT = 512 + DROP_STEPS;

    localparam logic [KW-1:0] K_KEY    = {4{"Key"}};
    localparam logic [KW-1:0] K_WIKI   = {3{"Wiki"}};
    localparam logic [KW-1:0] K_SECRET = {2{"Secret"}};

    logic          clk = 1'b0;
    logic          rst, start, busy, ready;
    logic [KW-1:0] key_in;
    logic          pt_valid, pt_ready, ct_valid, ct_ready;
    logic [7:0]    pt_data, ct_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] ms[256];
    int         mi, mj;

    always #5 clk = ~clk;

    rc4_stream_ctrl #(.KEY_LEN(KL), .SBOX_AW(8), .DROP_N(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .ready    (ready),
        .pt_valid (pt_valid),
        .pt_data  (pt_data),
        .pt_ready (pt_ready),
        .ct_valid (ct_valid),
        .ct_data  (ct_data),
        .ct_ready (ct_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_ks(output logic [7:0] ks);
        logic [7:0] t;
        mi = (mi + 1) % 256;
        mj = (mj + ms[mi]) % 256;
        t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
        ks = ms[(ms[mi] + ms[mj]) % 256];
    endtask

    task automatic model_key(input logic [KW-1:0] k);
        int         jj;
        logic [7:0] t;
        for (int c = 0; c < 256; c++) ms[c] = 8'(c);
        jj = 0;
        for (int c = 0; c < 256; c++) begin
            jj = (jj + ms[c] + k[8*(KL-1-(c%KL)) +: 8]) % 256;
            t = ms[c]; ms[c] = ms[jj]; ms[jj] = t;
        end
        mi = 0;
        mj = 0;
        for (int d = 0; d < DROP_STEPS; d++) model_ks(t);
    endtask

    task automatic issue_start(input logic [KW-1:0] k);
        @(negedge clk);
        start = 1'b1; key_in = k; pt_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
    endtask

    // Counts edges after the start edge until ready; optionally pokes start mid-KSA.
    task automatic wait_ready(input logic [KW-1:0] k, input bit poke);
        int n = 0;
        while (!ready && n < 3000) begin
            @(posedge clk); #1;
            n++;
            start = poke && (n == 300);
        end
        start = 1'b0;
        check_eq("start_to_ready", n, LAT);
        model_key(k);
    endtask

    task automatic stream(input logic [127:0] msg, input int n, input int mode);
        int         sent = 0;
        int         cyc  = 0;
        bit         hold_v = 1'b0;
        logic [7:0] held = 8'h00;
        logic [7:0] ks;
        got_q.delete();
        while ((sent < n || exp_q.size() > 0) && cyc < 200) begin
            @(negedge clk);
            ct_ready = (mode == 0) ? 1'b1 : (cyc % 2 == 1);
            pt_valid = (sent < n);
            pt_data  = pt_valid ? msg[8*(n-1-sent) +: 8] : 8'h00;
            #1;
            if (hold_v) begin
                check_eq("ct_hold_valid", ct_valid, 1);
                check_eq("ct_hold_data", ct_data, held);
            end
            hold_v = ct_valid && !ct_ready;
            held   = ct_data;
            if (ct_valid && ct_ready) begin
                if (exp_q.size() == 0) check_eq("ct_extra", ct_valid, 0);
                else                   check_eq("ct_data", ct_data, exp_q.pop_front());
                got_q.push_back(ct_data);
            end
            if (pt_valid && pt_ready) begin
                model_ks(ks);
                exp_q.push_back(pt_data ^ ks);
                sent++;
            end
            cyc++;
        end
        pt_valid = 1'b0;
        check_eq("stream_left", exp_q.size() + (n - sent), 0);
        check_eq("stream_count", got_q.size(), n);
    endtask

    task automatic kat_check(input string tag, input logic [127:0] kat, input int n);
        logic [7:0] g;
        for (int k = 0; k < n; k++) begin
            g = (k < got_q.size()) ? got_q[k] : 8'hxx;
            check_eq(tag, g, kat[8*(n-1-k) +: 8]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; key_in = '0;
        pt_valid = 1'b1; pt_data = 8'h00; ct_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", ready, 0);
        check_eq("rst_ct_valid", ct_valid, 0);
        check_eq("rst_ct_data", ct_data, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("idle_pt_ready", pt_ready, 0);
        check_eq("idle_busy", busy, 0);
        pt_valid = 1'b0;

        // "Key" / "Plaintext", full throughput
        issue_start(K_KEY);
        wait_ready(K_KEY, 1'b0);
        stream("Plaintext", 9, 0);
`ifndef RC4_DROP_EN
        kat_check("kat_plaintext", 72'hBBF316E8D940AF0AD3, 9);
`endif

        // "Secret" / "Attack at dawn", sink stalls every other cycle, start poked mid-KSA
        issue_start(K_SECRET);
        wait_ready(K_SECRET, 1'b1);
        stream("Attack at dawn", 14, 1);
`ifndef RC4_DROP_EN
        kat_check("kat_attack", 112'h45A01F645FC35B383552544B9BF5, 14);
`endif

        // "Wiki": restart while a ciphertext byte is pending
        issue_start(K_WIKI);
        wait_ready(K_WIKI, 1'b0);
        stream("Wi", 2, 0);
        @(negedge clk);
        ct_ready = 1'b0; pt_valid = 1'b1; pt_data = "k";
        #1;
        check_eq("pt_ready_run", pt_ready, 1);
        @(posedge clk); #1;
        pt_valid = 1'b0;
        check_eq("ct_pending", ct_valid, 1);
        @(negedge clk);
        start = 1'b1; key_in = K_WIKI; ct_ready = 1'b1; pt_valid = 1'b1;
        #1;
        check_eq("pt_ready_start", pt_ready, 0);
        ct_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; pt_valid = 1'b0;
        check_eq("ct_dropped", ct_valid, 0);
        check_eq("busy_restart", busy, 1);
        wait_ready(K_WIKI, 1'b0);
        stream("pedia", 5, 0);
`ifndef RC4_DROP_EN
        kat_check("kat_pedia", 40'h1021BF0420, 5);
`endif

        // Reset mid-KSA, then the "Key" scenario again
        issue_start(K_KEY);
        repeat (300) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_ready", ready, 0);
        check_eq("midrst_ct_valid", ct_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        issue_start(K_KEY);
        wait_ready(K_KEY, 1'b0);
        stream("Plaintext", 9, 0);
`ifndef RC4_DROP_EN
        kat_check("kat_plaintext_rst", 72'hBBF316E8D940AF0AD3, 9);
`endif

        // Raw keystream for "Key": bytes 1..6, or 5..10 when four are dropped
        issue_start(K_KEY);
        wait_ready(K_KEY, 1'b0);
        stream(128'h0, 6, 0);
`ifdef RC4_DROP_EN
        kat_check("kat_keystream", 48'hB734CA72A719, 6);
`else
        kat_check("kat_keystream", 48'hEB9F7781B734, 6);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
